// File: rtl/async_down_counter_pkg.sv
// ----------------------------------------------------------------------------
// async_down_counter_pkg
//   Shared constants for the ripple down counter and its toggle stages.
//
//   ADC_DEFAULT_WIDTH : default number of counter stages
//   ADC_MAX_WIDTH     : largest supported number of stages
// ----------------------------------------------------------------------------
package async_down_counter_pkg;

  localparam int unsigned ADC_DEFAULT_WIDTH = 3;
  localparam int unsigned ADC_MAX_WIDTH     = 16;

endpackage : async_down_counter_pkg

// File: rtl/adc_toggle_stage.sv
// ----------------------------------------------------------------------------
// adc_toggle_stage
//   One stage of the ripple down counter: a T flop that inverts on every
//   rising edge of its own stage clock. Reset is asynchronous and active-high
//   and loads RST_BIT.
//
//   Parameters:
//     RST_BIT : value held in the flop while reset is asserted
//   Ports:
//     tclk  in  1  stage clock (system clock for stage 0, lower q otherwise)
//     reset in  1  asynchronous active-high reset
//     q     out 1  stage output, straight from the flop
// ----------------------------------------------------------------------------
module adc_toggle_stage
  import async_down_counter_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic tclk,
  input  logic reset,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = ~q_q;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs as they were before the edge.
  always_ff @(posedge tclk or posedge reset) begin
    if (reset) begin
      q_q <= RST_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : adc_toggle_stage

// File: rtl/async_down_counter.sv
// ----------------------------------------------------------------------------
// async_down_counter
//   Ripple (asynchronous) binary down counter. Stage 0 toggles on every
//   rising edge of clk; stage i toggles when stage i-1 rises 0->1, which is
//   the borrow out of the lower bits. The net effect is a decrement by one per
//   clk rising edge, wrapping from 0 to 2^WIDTH-1. Outputs ripple through the
//   chain, so count must be sampled on the opposite clk edge or later.
//
//   Parameters:
//     WIDTH       : number of stages / bits of count (1..ADC_MAX_WIDTH)
//     RESET_VALUE : value forced onto count while reset is high (truncated)
//   Ports:
//     clk    in  1      counter clock
//     reset  in  1      asynchronous active-high reset
//     count  out WIDTH  current count, straight from the stage flops
//     borrow out 1      terminal-count flag, high when count is zero
//                       (present only when ASYNC_DOWN_COUNTER_BORROW_EN is
//                       defined)
//
//   Build option: define ASYNC_DOWN_COUNTER_BORROW_EN to add the borrow port.
// ----------------------------------------------------------------------------
module async_down_counter
  import async_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = ADC_DEFAULT_WIDTH,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
  ,
  output logic             borrow
`endif
);

  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VALUE);

  if (WIDTH < 1 || WIDTH > ADC_MAX_WIDTH) begin : g_bad_width
    $error("async_down_counter: WIDTH must be within 1..%0d", ADC_MAX_WIDTH);
  end

  logic [WIDTH-1:0] stage_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic tclk;

    // NOTE: each upper stage is clocked by the stage below it; this is the
    // deliberate ripple structure, so no common clock reaches those flops.
    if (i == 0) begin : g_first
      assign tclk = clk;
    end else begin : g_chain
      assign tclk = stage_q[i-1];
    end

    adc_toggle_stage #(
      .RST_BIT (RST_VEC[i])
    ) u_stage (
      .tclk  (tclk),
      .reset (reset),
      .q     (stage_q[i])
    );
  end

  assign count = stage_q;

`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
  // Terminal-count decode; glitches while the chain ripples, like count.
  assign borrow = (stage_q == '0);
`endif

endmodule : async_down_counter

// File: tb/tb_async_down_counter.sv
// ----------------------------------------------------------------------------
// tb_async_down_counter
//   Three counter instances share clk/reset: 3-bit from 0, 3-bit from 5 and
//   8-bit from 0. Expected values come from a table of the documented
//   sequence and from an arithmetic model: count = (RESET_VALUE - edges)
//   mod 2^WIDTH, where edges counts clk rises since reset was released.
// ----------------------------------------------------------------------------
module tb_async_down_counter;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] c3;
  logic [2:0] c5;
  logic [7:0] c8;
`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
  logic       b3;
  logic       b5;
  logic       b8;
`endif

  always #5 clk = ~clk;

  async_down_counter #(.WIDTH(3), .RESET_VALUE(0)) dut3 (
    .clk   (clk),
    .reset (reset),
    .count (c3)
`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
    ,
    .borrow (b3)
`endif
  );

  async_down_counter #(.WIDTH(3), .RESET_VALUE(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .count (c5)
`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
    ,
    .borrow (b5)
`endif
  );

  async_down_counter #(.WIDTH(8), .RESET_VALUE(0)) dut8 (
    .clk   (clk),
    .reset (reset),
    .count (c8)
`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
    ,
    .borrow (b8)
`endif
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int edges   = 0;

  typedef struct {
    logic [2:0] c3;
    logic [2:0] c5;
    logic       b3;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input int rv, input int w, input int n);
    int m;
    int v;
    m = 1 << w;
    v = (rv % m) - (n % m);
    if (v < 0) v += m;
    return 32'(v);
  endfunction

  task automatic check_all(input string tag);
    check({tag, " c3"}, 32'(c3), model(0, 3, edges));
    check({tag, " c5"}, 32'(c5), model(5, 3, edges));
    check({tag, " c8"}, 32'(c8), model(0, 8, edges));
`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
    check({tag, " b3"}, 32'(b3), 32'(model(0, 3, edges) == 0));
    check({tag, " b5"}, 32'(b5), 32'(model(5, 3, edges) == 0));
    check({tag, " b8"}, 32'(b8), 32'(model(0, 8, edges) == 0));
`endif
  endtask

  // One clk period: count the rise if not in reset, sample on the fall.
  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) edges++;
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    tbl[0]  = '{3'd7, 3'd4, 1'b0};
    tbl[1]  = '{3'd6, 3'd3, 1'b0};
    tbl[2]  = '{3'd5, 3'd2, 1'b0};
    tbl[3]  = '{3'd4, 3'd1, 1'b0};
    tbl[4]  = '{3'd3, 3'd0, 1'b0};
    tbl[5]  = '{3'd2, 3'd7, 1'b0};
    tbl[6]  = '{3'd1, 3'd6, 1'b0};
    tbl[7]  = '{3'd0, 3'd5, 1'b1};
    tbl[8]  = '{3'd7, 3'd4, 1'b0};
    tbl[9]  = '{3'd6, 3'd3, 1'b0};
    tbl[10] = '{3'd5, 3'd2, 1'b0};
    tbl[11] = '{3'd4, 3'd1, 1'b0};
    tbl[12] = '{3'd3, 3'd0, 1'b0};
    tbl[13] = '{3'd2, 3'd7, 1'b0};
    tbl[14] = '{3'd1, 3'd6, 1'b0};
    tbl[15] = '{3'd0, 3'd5, 1'b1};

    // Reset pulse 10..20 ns; values appear without needing a clk edge.
    #10 reset = 1'b1;
    #2;
    check("rst c3", 32'(c3), 32'd0);
    check("rst c5", 32'(c5), 32'd5);
    check("rst c8", 32'(c8), 32'd0);
`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
    check("rst b3", 32'(b3), 32'd1);
    check("rst b5", 32'(b5), 32'd0);
`endif
    #8 reset = 1'b0;
    edges = 0;

    // Two full wraps from the documented sequence table.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      check($sformatf("tbl%0d c3", i), 32'(c3), 32'(tbl[i].c3));
      check($sformatf("tbl%0d c5", i), 32'(c5), 32'(tbl[i].c5));
`ifdef ASYNC_DOWN_COUNTER_BORROW_EN
      check($sformatf("tbl%0d b3", i), 32'(b3), 32'(tbl[i].b3));
`endif
      check_all($sformatf("tbl%0d mdl", i));
    end

    // Asynchronous reset between edges, then held across clk edges.
    @(posedge clk);
    edges++;
    #3 reset = 1'b1;
    edges = 0;
    #1;
    check("async c3", 32'(c3), 32'd0);
    check("async c5", 32'(c5), 32'd5);
    check("async c8", 32'(c8), 32'd0);
    for (int i = 0; i < 2; i++) step($sformatf("hold%0d", i));
    #2 reset = 1'b0;

    // Full 8-bit period: first edge wraps to ff, edge 256 returns to 00.
    for (int i = 1; i <= 256; i++) begin
      step($sformatf("w8 e%0d", i));
      if (i == 1)   check("w8 first", 32'(c8), 32'hff);
      if (i == 256) check("w8 wrap", 32'(c8), 32'h00);
    end

    // Random run lengths with reset asserted and released at random
    // points away from clk edges.
    for (int r = 0; r < 20; r++) begin
      int run;
      int hold;
      run  = int'($urandom_range(1, 40));
      hold = int'($urandom_range(0, 2));
      for (int k = 0; k < run; k++) step($sformatf("rnd%0d", r));
      @(posedge clk);
      edges++;
      #($urandom_range(1, 4)) reset = 1'b1;
      edges = 0;
      #1 check_all($sformatf("rnd%0d rst", r));
      for (int k = 0; k < hold; k++) step($sformatf("rnd%0d hold", r));
      @(negedge clk);
      #($urandom_range(1, 3)) reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_async_down_counter
